// File: rtl/irq_timer_unit_if.sv
// irq_timer_unit_if: CPU-facing bus and interrupt handshake of irq_timer_unit.
//   a/d/we/rd      : word address, write data (bus byte order), strobes
//   spo/ready      : read data (bus byte order), request complete / idle
//   eip/eip_istimer: interrupt request to CPU, request is the timer
//   eip_reply      : one-cycle CPU acknowledge
interface irq_timer_unit_if;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;
    logic        ready;
    logic        eip;
    logic        eip_istimer;
    logic        eip_reply;

    modport master (output a, d, we, rd, eip_reply,
                    input  spo, ready, eip, eip_istimer);
    modport slave  (input  a, d, we, rd, eip_reply,
                    output spo, ready, eip, eip_istimer);
endinterface

// File: rtl/irq_timer_unit.sv
// irq_timer_unit: 64-bit machine timer plus external interrupt latch/enable
// bank, with a claim/complete interrupt handshake toward the CPU.
//   clk, rst  : clock, asynchronous active-high reset
//   ext_irq_i : NEXT asynchronous level interrupt sources
//   bus       : slave side of irq_timer_unit_if (register bus + eip handshake)
// Register map on a[4:2]: 0/1 MTIME lo/hi, 2/3 MTIMECMP lo/hi, 4 PENDING (W1C),
// 5 ENABLE, 6 CLAIM, 7 COMPLETE. Bus words are byte-swapped vs. registers.
module irq_timer_unit #(
    parameter int NEXT     = 4,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NEXT-1:0] ext_irq_i,
    irq_timer_unit_if.slave bus
);
    typedef enum logic       {B_IDLE, B_RESP} bstate_e;
    typedef enum logic [1:0] {I_IDLE, I_ASSERT, I_SERVICE} istate_e;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    bstate_e         bstate_q, bstate_d;
    istate_e         istate_q, istate_d;
    logic [63:0]     mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [31:0]     presc_q, presc_d;
    logic [NEXT:0]   en_q, en_d;
    logic [NEXT-1:0] pend_q, pend_d;
    logic [31:0]     claim_q, claim_d, spo_q, spo_d;
    logic [NEXT-1:0] sync0_q, sync1_q, sync2_q;
    logic            sel_tmr_q, sel_tmr_d;
    logic [4:0]      sel_idx_q, sel_idx_d;

    logic            wr_en, rd_en, complete_w, reply_take, timer_pend, any_ext;
    logic [2:0]      idx;
    logic [31:0]     wdata, rdata;
    logic [NEXT-1:0] rise, ext_act;
    logic [4:0]      first_idx;
    logic            unused_a;

    assign idx      = bus.a[4:2];
    assign wdata    = bswap(bus.d);
    assign unused_a = ^{bus.a[31:5], bus.a[1:0]};

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bstate_q <= B_IDLE;
        else     bstate_q <= bstate_d;
    end

    always_comb begin
        bstate_d = bstate_q;
        case (bstate_q)
            B_IDLE:  if (bus.rd || bus.we) bstate_d = B_RESP;
            default: bstate_d = B_IDLE;
        endcase
    end

    // ready is low in the strobe cycle itself and in RESP
    always_comb begin
        bus.ready = (bstate_q == B_IDLE) && !bus.rd && !bus.we;
        bus.spo   = spo_q;
    end

    // strobes while busy are dropped; rd together with we counts as a write
    assign wr_en      = (bstate_q == B_IDLE) && bus.we;
    assign rd_en      = (bstate_q == B_IDLE) && bus.rd && !bus.we;
    assign complete_w = wr_en && (idx == 3'd7) && (istate_q == I_SERVICE);
    assign reply_take = (istate_q == I_ASSERT) && bus.eip_reply;

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        case (idx)
            3'd0: rdata = mtime_q[31:0];
            3'd1: rdata = mtime_q[63:32];
            3'd2: rdata = mtimecmp_q[31:0];
            3'd3: rdata = mtimecmp_q[63:32];
            3'd4: rdata[NEXT:0] = {pend_q, timer_pend};
            3'd5: rdata[NEXT:0] = en_q;
            3'd6: rdata = claim_q;
            default: rdata = '0;
        endcase
        spo_d = rd_en ? bswap(rdata) : spo_q;
    end

    // ---------------- timer ----------------
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        presc_d    = presc_q;
        // a software write to mtime beats the increment and restarts the prescaler
        if (wr_en && idx == 3'd0) begin
            mtime_d[31:0] = wdata;
            presc_d       = '0;
        end else if (wr_en && idx == 3'd1) begin
            mtime_d[63:32] = wdata;
            presc_d        = '0;
        end else if (presc_q == 32'(PRESCALE - 1)) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + 32'd1;
        end
        if (wr_en && idx == 3'd2) mtimecmp_d[31:0]  = wdata;
        if (wr_en && idx == 3'd3) mtimecmp_d[63:32] = wdata;
    end

    assign timer_pend = en_q[0] && (mtime_q >= mtimecmp_q);

    // ---------------- external sources ----------------
    // sync0/sync1 resynchronize; sync2 holds the previous level for edge detect
    assign rise    = sync1_q & ~sync2_q;
    assign ext_act = pend_q & en_q[NEXT:1];
    assign any_ext = |ext_act;

    always_comb begin
        en_d   = en_q;
        pend_d = pend_q;
        if (wr_en && idx == 3'd5) en_d = wdata[NEXT:0];
        if (wr_en && idx == 3'd4) pend_d = pend_d & ~wdata[NEXT:1];
        if (reply_take && !sel_tmr_q)
            for (int i = 0; i < NEXT; i++)
                if (sel_idx_q == 5'(i)) pend_d[i] = 1'b0;
        // a new edge wins over any same-cycle clear
        pend_d = pend_d | rise;
    end

    always_comb begin
        first_idx = '0;
        for (int i = NEXT - 1; i >= 0; i--)
            if (ext_act[i]) first_idx = 5'(i);
    end

    // ---------------- IRQ FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) istate_q <= I_IDLE;
        else     istate_q <= istate_d;
    end

    always_comb begin
        istate_d  = istate_q;
        sel_tmr_d = sel_tmr_q;
        sel_idx_d = sel_idx_q;
        claim_d   = claim_q;
        case (istate_q)
            I_IDLE: begin
                // selection tracks while idle, so it is frozen from entry into ASSERT
                sel_tmr_d = timer_pend;
                sel_idx_d = first_idx;
                if (timer_pend || any_ext) istate_d = I_ASSERT;
            end
            I_ASSERT: if (bus.eip_reply) begin
                istate_d = I_SERVICE;
                claim_d  = sel_tmr_q ? 32'd0 : {27'd0, sel_idx_q} + 32'd1;
            end
            I_SERVICE: if (complete_w) begin
                istate_d = I_IDLE;
                claim_d  = '1;
            end
            default: istate_d = I_IDLE;
        endcase
    end

    always_comb begin
        bus.eip         = (istate_q == I_ASSERT);
        bus.eip_istimer = (istate_q == I_ASSERT) && sel_tmr_q;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            en_q       <= '0;
            pend_q     <= '0;
            claim_q    <= '1;
            spo_q      <= '0;
            sync0_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sel_tmr_q  <= 1'b0;
            sel_idx_q  <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            claim_q    <= claim_d;
            spo_q      <= spo_d;
            sync0_q    <= ext_irq_i;
            sync1_q    <= sync0_q;
            sync2_q    <= sync1_q;
            sel_tmr_q  <= sel_tmr_d;
            sel_idx_q  <= sel_idx_d;
        end
    end
endmodule

// File: tb/tb_irq_timer_unit.sv
// tb_irq_timer_unit: directed plus randomized bench for irq_timer_unit with a
// behavioural model (mtime as base + elapsed cycles, pending as a bit set).
module tb_irq_timer_unit;
    localparam int NEXT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NEXT-1:0] ext_irq = '0;

    irq_timer_unit_if bus();

    irq_timer_unit #(.NEXT(NEXT), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .ext_irq_i(ext_irq), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_cyc;

    function automatic logic [31:0] swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [31:0] val);
        @(negedge clk);
        bus.a = 32'(idx * 4); bus.d = swap(val); bus.we = 1'b1;
        @(negedge clk);
        last_cyc = cyc; bus.we = 1'b0;
        @(negedge clk);
    endtask

    task automatic rdreg(input int idx, output logic [31:0] val);
        @(negedge clk);
        bus.a = 32'(idx * 4); bus.rd = 1'b1;
        @(negedge clk);
        last_cyc = cyc; bus.rd = 1'b0; val = swap(bus.spo);
        @(negedge clk);
    endtask

    task automatic wait_eip(input string tag);
        for (int i = 0; i < 64 && bus.eip !== 1'b1; i++) @(negedge clk);
        chk(tag, bus.eip, 1);
    endtask

    task automatic reply();
        @(negedge clk); bus.eip_reply = 1'b1;
        @(negedge clk); bus.eip_reply = 1'b0;
    endtask

    task automatic pulse(input logic [NEXT-1:0] m);
        @(negedge clk); ext_irq = m;
        repeat (4) @(negedge clk);
        ext_irq = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]       v, e;
        logic [31:0]       hh, ll;
        longint unsigned   base, expm;
        int                t0, first;
        logic [NEXT-1:0]   mpend, men;
        int                lo;

        bus.a = '0; bus.d = '0; bus.we = 1'b0; bus.rd = 1'b0; bus.eip_reply = 1'b0;

        // reset state
        #2 rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_spo", bus.spo, 0);
        chk("rst_ready", bus.ready, 1);
        chk("rst_eip", bus.eip, 0);
        chk("rst_istimer", bus.eip_istimer, 0);
        @(negedge clk); rst = 1'b0;

        // read latency on CLAIM
        @(negedge clk); bus.a = 32'h18; bus.rd = 1'b1; #1;
        chk("lat_ready_T", bus.ready, 0);
        @(negedge clk); bus.rd = 1'b0; #1;
        chk("lat_ready_T1", bus.ready, 0);
        chk("lat_spo_T1", bus.spo, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        chk("lat_ready_T2", bus.ready, 1);

        // byte order
        wr(2, 32'h1234_5678);
        chk("bo_internal", dut.mtimecmp_q[31:0], 32'h1234_5678);
        rdreg(2, v);
        chk("bo_spo_raw", bus.spo, 32'h7856_3412);

        // random register readback
        for (int k = 0; k < 4; k++) begin
            v = $urandom; wr(3, v); rdreg(3, e); chk("rw_cmphi", e, v);
            v = $urandom; wr(5, v); rdreg(5, e); chk("rw_enable", e, v & 32'h1F);
        end
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;

        // mtime: model is written value plus elapsed cycles, 64-bit wrap
        for (int k = 0; k < 4; k++) begin
            hh = $urandom; ll = $urandom;
            if (k == 2) ll = 32'hFFFF_FFFC;
            if (k == 3) begin hh = '1; ll = '1; end
            wr(0, 0); wr(1, hh); wr(0, ll);
            base = {hh, ll}; t0 = last_cyc;
            rdreg(0, v); expm = base + longint'(last_cyc - t0 - 1);
            chk("mtime_lo", v, expm[31:0]);
            rdreg(1, v); expm = base + longint'(last_cyc - t0 - 1);
            chk("mtime_hi", v, expm[63:32]);
        end

        // timer interrupt at mtime >= 20
        wr(0, 0); wr(1, 0); wr(0, 0); t0 = last_cyc;
        wr(2, 20); wr(3, 0); wr(5, 1);
        first = -1;
        for (int i = 0; i < 64 && bus.eip !== 1'b1; i++) @(negedge clk);
        first = cyc - t0;
        chk("tmr_eip", bus.eip, 1);
        chk("tmr_latency", first, 21);
        chk("tmr_istimer", bus.eip_istimer, 1);
        reply();
        chk("tmr_eip_drop", bus.eip, 0);
        rdreg(6, v); chk("tmr_claim", v, 0);
        rdreg(4, v); chk("tmr_pending", v, 1);
        wr(7, 32'hDEAD_BEEF);
        chk("tmr_reassert", bus.eip, 1);
        wr(5, 0);
        chk("tmr_disable_holds", bus.eip, 1);
        reply(); wr(7, 0);
        chk("tmr_idle", bus.eip, 0);
        rdreg(6, v); chk("tmr_claim_none", v, 32'hFFFF_FFFF);

        // external priority
        wr(5, 32'h6);
        pulse(4'b0011);
        wait_eip("ext_eip");
        chk("ext_istimer", bus.eip_istimer, 0);
        reply();
        rdreg(6, v); chk("ext_claim1", v, 1);
        rdreg(4, v); chk("ext_pend1", v, 32'h4);
        wr(7, 0);
        wait_eip("ext_reassert");
        reply();
        rdreg(6, v); chk("ext_claim2", v, 2);
        rdreg(4, v); chk("ext_pend2", v, 0);
        wr(7, 0);

        // randomized external sources against a bit-set model
        for (int k = 0; k < 3; k++) begin
            mpend = 4'($urandom_range(1, 15));
            men   = 4'($urandom_range(0, 15));
            wr(5, {27'd0, men, 1'b0});
            pulse(mpend);
            for (int n = 0; n < NEXT && (mpend & men) != 0; n++) begin
                wait_eip("rnd_eip");
                chk("rnd_istimer", bus.eip_istimer, 0);
                reply();
                lo = 0;
                while (!(mpend[lo] && men[lo])) lo++;
                rdreg(6, v); chk("rnd_claim", v, lo + 1);
                mpend[lo] = 1'b0;
                rdreg(4, v); chk("rnd_pend", v, {27'd0, mpend, 1'b0});
                wr(7, 0);
            end
            repeat (2) @(negedge clk);
            chk("rnd_quiet", bus.eip, 0);
            rdreg(4, v); chk("rnd_leftover", v, {27'd0, mpend, 1'b0});
            wr(4, {27'd0, mpend, 1'b0});
            rdreg(4, v); chk("rnd_w1c", v, 0);
        end
        wr(5, 0);

        // rd and we together: write happens, spo untouched
        rdreg(6, v);
        @(negedge clk); bus.a = 32'h14; bus.d = swap(32'h4); bus.rd = 1'b1; bus.we = 1'b1;
        @(negedge clk); bus.rd = 1'b0; bus.we = 1'b0;
        @(negedge clk);
        chk("rdwe_spo", bus.spo, 32'hFFFF_FFFF);
        rdreg(5, v); chk("rdwe_write", v, 4);
        wr(5, 0);

        // W1C colliding with a new edge on the same bit
        pulse(4'b0100);
        rdreg(4, v); chk("w1c_pre", v, 8);
        @(negedge clk); ext_irq = 4'b0100;
        @(negedge clk);
        @(negedge clk); bus.a = 32'h10; bus.d = swap(32'h8); bus.we = 1'b1;
        @(negedge clk); bus.we = 1'b0;
        @(negedge clk);
        rdreg(4, v); chk("w1c_vs_set", v, 8);
        ext_irq = '0;
        repeat (4) @(negedge clk);
        wr(4, 8);
        rdreg(4, v); chk("w1c_clear", v, 0);

        // reset in the middle of a read response with eip high
        wr(3, 0); wr(2, 0); wr(5, 1);
        wait_eip("rst_pre_eip");
        @(negedge clk); bus.a = 32'h0; bus.rd = 1'b1;
        @(negedge clk); bus.rd = 1'b0; rst = 1'b1; #1;
        chk("midrst_ready", bus.ready, 1);
        chk("midrst_eip", bus.eip, 0);
        chk("midrst_istimer", bus.eip_istimer, 0);
        chk("midrst_spo", bus.spo, 0);
        @(negedge clk); rst = 1'b0;
        rdreg(2, v); chk("post_cmplo", v, 32'hFFFF_FFFF);
        rdreg(3, v); chk("post_cmphi", v, 32'hFFFF_FFFF);
        rdreg(5, v); chk("post_enable", v, 0);
        rdreg(6, v); chk("post_claim", v, 32'hFFFF_FFFF);
        rdreg(4, v); chk("post_pending", v, 0);
        rdreg(1, v); chk("post_mtime_hi", v, 0);
        chk("post_eip", bus.eip, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/irq_timer_unit.md
Name: irq_timer_unit

Overview:
- Bus responder for the pCPU memory interface (a/d/we/rd/spo/ready).
- Provides a 64-bit machine timer (mtime/mtimecmp) and an external-interrupt latch/enable bank.
- Drives the CPU interrupt handshake eip/eip_istimer/eip_reply, including a claim/complete service model.
- Sits behind the system address decoder, which qualifies rd/we for this block's address window.

Parameters:
- NEXT, 4: number of external interrupt sources (1..31).
- PRESCALE, 1: clk cycles per mtime increment (>=1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- a, input, 32: bus address; only a[4:2] is decoded.
- d, input, 32: write data, in bus byte order.
- we, input, 1: one-cycle write strobe, already decoded for this block.
- rd, input, 1: one-cycle read strobe, already decoded for this block.
- spo, output, 32: read data, in bus byte order.
- ready, output, 1: request complete / idle.
- ext_irq, input, NEXT: asynchronous level interrupt sources.
- eip, output, 1: interrupt request to CPU.
- eip_istimer, output, 1: the asserted interrupt is the timer.
- eip_reply, input, 1: one-cycle CPU acknowledge.

Behaviour:
- Byte order: a bus word carries register byte 0 in d[31:24]. Internal value = byteswap(d); spo = byteswap(register).
- Register map, a[4:2]:
  - 0 MTIME_LO, R/W.
  - 1 MTIME_HI, R/W.
  - 2 MTIMECMP_LO, R/W.
  - 3 MTIMECMP_HI, R/W.
  - 4 PENDING, R; W1C on ext bits. Bit0 = timer pending (live), bits[NEXT:1] = ext pending.
  - 5 ENABLE, R/W. Bit0 = timer enable, bits[NEXT:1] = ext enables; other bits read 0.
  - 6 CLAIM, R. 0 = timer, i+1 = ext source i, 0xFFFFFFFF = none in service.
  - 7 COMPLETE, W-only; data ignored; reads 0.
- Bus FSM, states IDLE and RESP:
  - ready = ~busy & ~rd & ~we (combinational), so a strobe is never acknowledged in its own cycle.
  - IDLE, strobe seen: capture index and data; perform the write, or register the read value into spo; go to RESP (busy=1).
  - RESP lasts exactly one cycle; then IDLE.
  - Result: strobe at cycle T gives ready=0 at T and T+1, ready=1 at T+2, with spo valid from T+1 and held until the next read.
  - rd and we together: treated as a write; spo unchanged.
  - Strobes while busy are ignored.
- Timer:
  - Prescaler counts 0..PRESCALE-1; mtime increments on wrap. mtime wraps at 2^64-1 -> 0.
  - A bus write to MTIME_LO/HI overrides the same-cycle increment and clears the prescaler.
  - timer_pend = ENABLE[0] & (mtime >= mtimecmp), unsigned 64-bit compare.
- External sources:
  - ext_irq goes through a 2-flop synchronizer; a rising edge sets pending[i].
  - W1C write clears; a set in the same cycle wins over the clear.
- IRQ FSM, states I_IDLE, I_ASSERT, I_SERVICE:
  - I_IDLE -> I_ASSERT when timer_pend or any (ext pending & enable). Selection is latched on entry: timer has priority, then lowest i. eip_istimer = selected is timer.
  - I_ASSERT: eip=1; eip_istimer stable; selection frozen.
  - eip_reply in I_ASSERT: load CLAIM with the selection, clear the selected ext pending bit, go to I_SERVICE. eip_reply in any other state is ignored.
  - I_SERVICE: eip=0. A COMPLETE write sets CLAIM to 0xFFFFFFFF and returns to I_IDLE; if a source is still pending it re-asserts on the next cycle.
  - Disabling the selected source while in I_ASSERT does not drop eip.
- Reset, async, any state, including mid-transaction:
  - mtime=0, mtimecmp=all ones, pending=0, ENABLE=0, CLAIM=0xFFFFFFFF.
  - spo=0, busy=0 (ready=1 with no strobe), eip=0, eip_istimer=0.
  - Both FSMs to idle; synchronizers cleared.

Test Plan:
- Read latency: rd at T, a=0x18 after reset -> ready 0 at T and T+1, 1 at T+2; spo=0xFFFFFFFF from T+1.
- Byte order: write d=0x78563412 to a=0x08, then read a=0x08 -> spo=0x78563412; internal mtimecmp_lo=0x12345678.
- Timer interrupt, PRESCALE=1:
  - Setup: mtimecmp=20, ENABLE=1.
  - Required: eip=1 and eip_istimer=1 once mtime>=20.
  - eip_reply pulse -> eip=0; CLAIM reads 0.
  - COMPLETE write without changing mtimecmp -> eip re-asserts one cycle later.
- External priority:
  - Setup: ENABLE=0b110; pulse ext_irq[1] then ext_irq[0] in the same cycle.
  - Required: eip_istimer=0; after reply, CLAIM=1 and PENDING=0b100.
  - COMPLETE -> re-asserts; after reply, CLAIM=2.
- Simultaneous events:
  - rd=we=1 -> write performed, spo unchanged.
  - MTIME_LO write on an increment cycle -> written value wins.
  - W1C and new edge on the same bit in one cycle -> bit stays 1.
- Reset mid-RESP with eip=1 -> ready=1, eip=0 immediately; all registers at reset values.
